// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter: four WIDTH-bit sources share one registered output stage
// with a valid/ready handshake. The rotating pointer starts one past the last winner.
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data_a,
  input  logic [WIDTH-1:0] req_data_b,
  input  logic [WIDTH-1:0] req_data_c,
  input  logic [WIDTH-1:0] req_data_d,
  output logic [3:0]       req_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sel
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic             r_valid;

  logic             w_load;
  logic             w_found;
  logic [1:0]       w_grant;
  logic             w_take;
  logic [WIDTH-1:0] w_mux_data;
  logic [2:0]       w_arb;

  // Scans from the highest offset down so the lowest offset from r_ptr wins.
  function automatic logic [2:0] f_arbitrate(input logic [3:0] req, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + k[1:0];
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // The slot can take a new item when empty or when the held item leaves this cycle.
  assign w_load  = (r_state == ST_EMPTY) | ((r_state == ST_FULL) & out_ready);
  assign w_arb   = f_arbitrate(req_valid, r_ptr);
  assign w_found = w_arb[2];
  assign w_grant = w_arb[1:0];
  assign w_take  = w_load & w_found;

  always_comb begin
    w_mux_data = req_data_a;
    case (w_grant)
      2'd0:    w_mux_data = req_data_a;
      2'd1:    w_mux_data = req_data_b;
      2'd2:    w_mux_data = req_data_c;
      2'd3:    w_mux_data = req_data_d;
      default: w_mux_data = req_data_a;
    endcase
  end

  // Gated by rst_n so no capture pulse escapes while the stage is held in reset.
  assign req_ready = (rst_n & w_take) ? (4'b0001 << w_grant) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_ptr   <= 2'd0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_take) begin
            r_state <= ST_FULL;
            r_data  <= w_mux_data;
            r_sel   <= w_grant;
            r_valid <= 1'b1;
            r_ptr   <= w_grant + 2'd1;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (w_found) begin
              r_data  <= w_mux_data;
              r_sel   <= w_grant;
              r_valid <= 1'b1;
              r_ptr   <= w_grant + 2'd1;
            end else begin
              r_state <= ST_EMPTY;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= r_state;
          r_ptr   <= r_ptr;
          r_data  <= r_data;
          r_sel   <= r_sel;
          r_valid <= r_valid;
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule
